// File: rtl/avalon_st_sorter_if.sv
// Avalon-ST handshake bundle: data, packet delimiters, valid and ready.
// The master drives the payload and the slave drives ready.
interface avalon_st_sorter_if #(
    parameter int unsigned DWIDTH = 10
);
    logic [DWIDTH-1:0] data;
    logic              startofpacket;
    logic              endofpacket;
    logic              valid;
    logic              ready;

    modport master (
        output data, startofpacket, endofpacket, valid,
        input  ready
    );

    modport slave (
        input  data, startofpacket, endofpacket, valid,
        output ready
    );
endinterface

// File: rtl/avalon_st_sorter.sv
// Avalon-ST packet sorter: buffers one packet, bubble-sorts it in place, then streams it out.
// Receive, sort and send never overlap; only one packet is held at a time.
module avalon_st_sorter #(
    parameter int unsigned DWIDTH      = 10,
    parameter int unsigned MAX_PKT_LEN = 16,
    parameter int unsigned CTR_SZ      = $clog2(MAX_PKT_LEN + 1)
) (
    input  logic                clk_i,
    input  logic                srst_i,
    avalon_st_sorter_if.slave   snk,
    avalon_st_sorter_if.master  src,
    input  logic                sort_desc_i,
    output logic                overflow_o
);
    localparam int unsigned       AW     = $clog2(MAX_PKT_LEN);
    localparam logic [CTR_SZ-1:0] MaxLen = CTR_SZ'(MAX_PKT_LEN);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRecv = 2'd1;
    localparam logic [1:0] StSort = 2'd2;
    localparam logic [1:0] StSend = 2'd3;

    logic [DWIDTH-1:0] mem [MAX_PKT_LEN];

    logic [1:0]        state_q, state_d;
    logic [CTR_SZ-1:0] len_q, len_d;
    logic [CTR_SZ-1:0] idx_q, idx_d;
    logic              ovf_q, ovf_d;
    logic              desc_q, desc_d;
    logic              swap_q, swap_d;
    logic              ready_q, ready_d;
    logic              ovf_pulse_q, ovf_pulse_d;

    logic              snk_xfer, src_xfer;
    logic              wr_en, swap_en, do_swap;
    logic [AW-1:0]     wr_addr, j0, j1;
    logic [DWIDTH-1:0] cmp_lo, cmp_hi;

    // idx doubles as the compare pointer during SORT and the read pointer during SEND.
    assign j0     = idx_q[AW-1:0];
    assign j1     = j0 + AW'(1);
    assign cmp_lo = mem[j0];
    assign cmp_hi = mem[j1];

    // Strict compares keep equal words in arrival order.
    assign do_swap  = desc_q ? (cmp_lo < cmp_hi) : (cmp_lo > cmp_hi);
    assign snk_xfer = snk.valid & ready_q;
    assign src_xfer = (state_q == StSend) & src.ready;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        idx_d       = idx_q;
        ovf_d       = ovf_q;
        desc_d      = desc_q;
        swap_d      = swap_q;
        ovf_pulse_d = 1'b0;
        wr_en       = 1'b0;
        wr_addr     = len_q[AW-1:0];
        swap_en     = 1'b0;

        case (state_q)
            StIdle, StRecv: begin
                if (snk_xfer) begin
                    if (snk.startofpacket) begin
                        // A new SOP always restarts capture, abandoning any partial packet.
                        wr_en   = 1'b1;
                        wr_addr = '0;
                        len_d   = CTR_SZ'(1);
                        idx_d   = '0;
                        ovf_d   = 1'b0;
                        swap_d  = 1'b0;
                        desc_d  = sort_desc_i;
                        state_d = snk.endofpacket ? StSend : StRecv;
                    end else if (state_q == StRecv) begin
                        if (len_q < MaxLen) begin
                            wr_en = 1'b1;
                            len_d = len_q + CTR_SZ'(1);
                        end else begin
                            ovf_d = 1'b1;
                        end
                        if (snk.endofpacket) begin
                            idx_d       = '0;
                            swap_d      = 1'b0;
                            ovf_pulse_d = ovf_q | (len_q == MaxLen);
                            state_d     = StSort;
                        end
                    end
                end
            end
            StSort: begin
                swap_en = do_swap;
                if (idx_q == len_q - CTR_SZ'(2)) begin
                    idx_d  = '0;
                    swap_d = 1'b0;
                    if (!(swap_q | do_swap)) state_d = StSend;
                end else begin
                    idx_d  = idx_q + CTR_SZ'(1);
                    swap_d = swap_q | do_swap;
                end
            end
            default: begin
                if (src_xfer) begin
                    if (idx_q == len_q - CTR_SZ'(1)) begin
                        idx_d   = '0;
                        state_d = StIdle;
                    end else begin
                        idx_d = idx_q + CTR_SZ'(1);
                    end
                end
            end
        endcase

        ready_d = (state_d == StIdle) | (state_d == StRecv);
    end

    always_ff @(posedge clk_i) begin
        if (!srst_i) begin
            state_q     <= StIdle;
            len_q       <= '0;
            idx_q       <= '0;
            ovf_q       <= 1'b0;
            desc_q      <= 1'b0;
            swap_q      <= 1'b0;
            ready_q     <= 1'b0;
            ovf_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            ovf_q       <= ovf_d;
            desc_q      <= desc_d;
            swap_q      <= swap_d;
            ready_q     <= ready_d;
            ovf_pulse_q <= ovf_pulse_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            if (wr_en) begin
                mem[wr_addr] <= snk.data;
            end else if (swap_en) begin
                mem[j0] <= cmp_hi;
                mem[j1] <= cmp_lo;
            end
        end
    end

    assign snk.ready         = ready_q;
    assign src.valid         = (state_q == StSend);
    assign src.data          = src.valid ? cmp_lo : '0;
    assign src.startofpacket = src.valid & (idx_q == '0);
    assign src.endofpacket   = src.valid & (idx_q == len_q - CTR_SZ'(1));
    assign overflow_o        = ovf_pulse_q;
endmodule
